// File: rtl/fmadd_round_pack_pipe_pkg.sv
// fmadd_round_pack_pipe_pkg: rounding-mode encodings and fflags bit positions shared by the FMA round/pack paths
package fmadd_round_pack_pipe_pkg;
  typedef enum logic [2:0] {
    FRM_RNE = 3'b000,
    FRM_RTZ = 3'b001,
    FRM_RDN = 3'b010,
    FRM_RUP = 3'b011,
    FRM_RMM = 3'b100
  } frm_e;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
endpackage

// File: rtl/fmadd_round_incr.sv
// fmadd_round_incr: decides the round-up increment and inexact from rounding mode, sign and GRS bits
module fmadd_round_incr
  import fmadd_round_pack_pipe_pkg::*;
(
  input  logic [2:0] frm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       round,
  input  logic       sticky,
  output logic       inc,
  output logic       inexact
);
  // reserved encodings fall through to round-to-nearest-even
  always_comb begin
    inexact = guard | round | sticky;
    inc = (frm == FRM_RTZ) ? 1'b0 :
          (frm == FRM_RDN) ? (sign & inexact) :
          (frm == FRM_RUP) ? (!sign & inexact) :
          (frm == FRM_RMM) ? guard :
                             (guard & (round | sticky | lsb));
  end
endmodule

// File: rtl/fmadd_round_pack_pipe.sv
// fmadd_round_pack_pipe: two-register round-and-pack stage producing the IEEE result and fflags
module fmadd_round_pack_pipe
  import fmadd_round_pack_pipe_pkg::*;
#(
  parameter int std = 31,
  parameter int man = 22,
  parameter int exp = 7
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sign,
  input  logic [man+1:0] in_mantissa,
  input  logic [exp+1:0] in_exponent,
  input  logic           in_guard,
  input  logic           in_round,
  input  logic           in_sticky,
  input  logic [2:0]     in_frm,
  input  logic           in_special,
  input  logic [std:0]   in_special_result,
  input  logic [4:0]     in_special_flags,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [std:0]   out_result,
  output logic [4:0]     out_flags
);
  localparam logic [exp+2:0] EXP_MAX = {2'b00, {(exp+1){1'b1}}};
  localparam logic [exp+2:0] EXP_ONE = {{(exp+2){1'b0}}, 1'b1};
  logic           inc, inexact, s1_adv, s2_adv;
  logic           s1_valid, s1_sign, s1_inexact, s1_special;
  logic [man+2:0] s1_sum;
  logic [exp+1:0] s1_exp;
  logic [2:0]     s1_frm;
  logic [std:0]   s1_special_result, res_nxt;
  logic [4:0]     s1_special_flags, flags_nxt;
  logic           carry, ovf, inf_sel, tiny;
  logic [man+1:0] mant;
  logic [exp+2:0] exp_adj, exp_fld;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  fmadd_round_incr u_incr (
    .frm     (in_frm),
    .sign    (in_sign),
    .lsb     (in_mantissa[0]),
    .guard   (in_guard),
    .round   (in_round),
    .sticky  (in_sticky),
    .inc     (inc),
    .inexact (inexact)
  );

  // stage 1: capture the incremented mantissa and the fields needed to pack it
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid          <= 1'b0;
      s1_sign           <= 1'b0;
      s1_sum            <= '0;
      s1_exp            <= '0;
      s1_frm            <= '0;
      s1_inexact        <= 1'b0;
      s1_special        <= 1'b0;
      s1_special_result <= '0;
      s1_special_flags  <= '0;
    end else begin
      s1_valid <= flush ? 1'b0 : (s1_adv ? in_valid : s1_valid);
      if (s1_adv && in_valid) begin
        s1_sign           <= in_sign;
        s1_sum            <= {1'b0, in_mantissa} + {{(man+2){1'b0}}, inc};
        s1_exp            <= in_exponent;
        s1_frm            <= in_frm;
        s1_inexact        <= inexact;
        s1_special        <= in_special;
        s1_special_result <= in_special_result;
        s1_special_flags  <= in_special_flags;
      end
    end
  end

  // stage 2 datapath: renormalize the rounding carry, detect overflow/tininess and pack
  always_comb begin
    carry     = s1_sum[man+2];
    mant      = carry ? s1_sum[man+2:1] : s1_sum[man+1:0];
    exp_adj   = {1'b0, s1_exp} + {{(exp+2){1'b0}}, carry};
    exp_fld   = (exp_adj == '0 && mant[man+1]) ? EXP_ONE : exp_adj;
    ovf       = exp_fld >= EXP_MAX;
    tiny      = exp_fld == '0;
    inf_sel   = (s1_frm == FRM_RTZ) ? 1'b0 :
                (s1_frm == FRM_RDN) ? s1_sign :
                (s1_frm == FRM_RUP) ? !s1_sign : 1'b1;
    res_nxt   = s1_special ? s1_special_result :
                !ovf       ? {s1_sign, exp_fld[exp:0], mant[man:0]} :
                inf_sel    ? {s1_sign, {(exp+1){1'b1}}, {(man+1){1'b0}}} :
                             {s1_sign, {exp{1'b1}}, 1'b0, {(man+1){1'b1}}};
    flags_nxt = '0;
    flags_nxt[FLAG_OF] = ovf;
    flags_nxt[FLAG_UF] = tiny & s1_inexact;
    flags_nxt[FLAG_NX] = s1_inexact | ovf;
    if (s1_special) flags_nxt = s1_special_flags;
  end

  // stage 2 register: output holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : (s2_adv ? s1_valid : out_valid);
      if (s2_adv && s1_valid) begin
        out_result <= res_nxt;
        out_flags  <= flags_nxt;
      end
    end
  end
endmodule

// File: tb/tb_fmadd_round_pack_pipe.sv
// tb_fmadd_round_pack_pipe: directed vectors with a value-level rounding model and scoreboard
module tb_fmadd_round_pack_pipe;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [23:0] in_mantissa = '0;
  logic [8:0]  in_exponent = '0;
  logic        in_guard = 1'b0, in_round = 1'b0, in_sticky = 1'b0;
  logic [2:0]  in_frm = '0;
  logic        in_special = 1'b0;
  logic [31:0] in_special_result = '0;
  logic [4:0]  in_special_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        sign;
    logic [23:0] mant;
    logic [8:0]  expo;
    logic [2:0]  grs;
    logic [2:0]  frm;
    logic        sp;
    logic [31:0] spr;
    logic [4:0]  spf;
    logic [31:0] res;
    logic [4:0]  flg;
  } op_t;

  op_t tbl[14];
  logic [36:0] sb[$];
  logic        have_hold = 1'b0;
  logic [36:0] held;

  fmadd_round_pack_pipe dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_sign           (in_sign),
    .in_mantissa       (in_mantissa),
    .in_exponent       (in_exponent),
    .in_guard          (in_guard),
    .in_round          (in_round),
    .in_sticky         (in_sticky),
    .in_frm            (in_frm),
    .in_special        (in_special),
    .in_special_result (in_special_result),
    .in_special_flags  (in_special_flags),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_flags         (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // value-level rounding: treat {G,R,S} as a fraction of one ulp and round the integer mantissa
  function automatic logic [36:0] model(input logic sign, input logic [23:0] m, input logic [8:0] e,
                                        input logic [2:0] grs, input logic [2:0] frm, input logic sp,
                                        input logic [31:0] spr, input logic [4:0] spf);
    int     rem = int'(grs);
    bit     nx = rem != 0;
    bit     up, inf;
    longint v;
    int     ex;
    if (sp) return {spr, spf};
    case (frm)
      3'd1:    up = 0;
      3'd2:    up = sign && nx;
      3'd3:    up = !sign && nx;
      3'd4:    up = rem >= 4;
      default: up = rem > 4 || (rem == 4 && m[0]);
    endcase
    v  = longint'(m) + (up ? 1 : 0);
    ex = int'(e);
    if (v >= 64'd16777216) begin
      v  = v / 2;
      ex = ex + 1;
    end
    if (ex == 0 && v >= 64'd8388608) ex = 1;
    if (ex >= 255) begin
      inf = (frm == 3'd1) ? 0 : (frm == 3'd2) ? sign : (frm == 3'd3) ? !sign : 1;
      return {inf ? {sign, 8'hFF, 23'h0} : {sign, 8'hFE, 23'h7FFFFF}, 5'b00101};
    end
    return {sign, ex[7:0], v[22:0], 3'b000, (ex == 0 && nx), nx};
  endfunction

  function automatic op_t mk(input string n, input logic s, input logic [23:0] m, input logic [8:0] e,
                             input logic [2:0] grs, input logic [2:0] f, input logic [31:0] r, input logic [4:0] fl);
    op_t o;
    o.name = n; o.sign = s; o.mant = m; o.expo = e; o.grs = grs; o.frm = f;
    o.sp = 1'b0; o.spr = '0; o.spf = '0; o.res = r; o.flg = fl;
    return o;
  endfunction

  task automatic drive(input op_t o);
    in_sign = o.sign; in_mantissa = o.mant; in_exponent = o.expo;
    {in_guard, in_round, in_sticky} = o.grs; in_frm = o.frm;
    in_special = o.sp; in_special_result = o.spr; in_special_flags = o.spf;
  endtask

  // single op through an empty pipe, checking the two-edge latency
  task automatic run_op(input op_t o);
    @(posedge clk); #1;
    drive(o);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({o.name, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({o.name, "_lat2"}, 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  // scoreboard: every output transfer must match the oldest accepted op, stalled outputs must hold
  always @(negedge clk) begin
    if (!rst_l) begin
      sb.delete();
      have_hold = 1'b0;
    end else begin
      if (have_hold && out_valid) chk("hold_stable", 64'({out_result, out_flags}), 64'(held));
      have_hold = out_valid && !out_ready && !flush;
      held = {out_result, out_flags};
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) chk("unexpected_output", 64'({out_result, out_flags}), 64'h1_0000_0000_0);
        else chk("result", 64'({out_result, out_flags}), 64'(sb.pop_front()));
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back(model(in_sign, in_mantissa, in_exponent, {in_guard, in_round, in_sticky}, in_frm,
                           in_special, in_special_result, in_special_flags));
    end
  end

  initial begin
    int idx;
    bit acc;
    tbl[0]  = mk("rne_carry",  0, 24'hFFFFFF, 9'd127, 3'b100, 3'd0, 32'h40000000, 5'b00001);
    tbl[1]  = mk("tie_rne",    0, 24'h800000, 9'd127, 3'b100, 3'd0, 32'h3F800000, 5'b00001);
    tbl[2]  = mk("tie_rup",    0, 24'h800000, 9'd127, 3'b100, 3'd3, 32'h3F800001, 5'b00001);
    tbl[3]  = mk("tie_rmm",    0, 24'h800000, 9'd127, 3'b100, 3'd4, 32'h3F800001, 5'b00001);
    tbl[4]  = mk("of_rne",     0, 24'hFFFFFF, 9'd254, 3'b100, 3'd0, 32'h7F800000, 5'b00101);
    tbl[5]  = mk("trunc_rtz",  0, 24'hFFFFFF, 9'd254, 3'b100, 3'd1, 32'h7F7FFFFF, 5'b00001);
    tbl[6]  = mk("head_rne",   0, 24'h800000, 9'h100, 3'b000, 3'd0, 32'h7F800000, 5'b00101);
    tbl[7]  = mk("sub_up",     0, 24'h7FFFFF, 9'd0,   3'b100, 3'd0, 32'h00800000, 5'b00001);
    tbl[8]  = mk("sub_tiny",   0, 24'h000001, 9'd0,   3'b110, 3'd1, 32'h00000001, 5'b00011);
    tbl[9]  = mk("rdn_neg",    1, 24'h800000, 9'd127, 3'b010, 3'd2, 32'hBF800001, 5'b00001);
    tbl[10] = mk("head_rdn",   0, 24'h800000, 9'h100, 3'b000, 3'd2, 32'h7F7FFFFF, 5'b00101);
    tbl[11] = mk("rsv_frm",    0, 24'h800001, 9'd127, 3'b100, 3'd7, 32'h3F800002, 5'b00001);
    tbl[12] = mk("special",    0, 24'hFFFFFF, 9'd254, 3'b111, 3'd0, 32'h7FC00000, 5'b10000);
    tbl[12].sp = 1'b1; tbl[12].spr = 32'h7FC00000; tbl[12].spf = 5'b10000;
    tbl[13] = mk("exact",      0, 24'h800000, 9'd127, 3'b000, 3'd0, 32'h3F800000, 5'b00000);

    foreach (tbl[i])
      chk({"model_", tbl[i].name},
          64'(model(tbl[i].sign, tbl[i].mant, tbl[i].expo, tbl[i].grs, tbl[i].frm, tbl[i].sp, tbl[i].spr, tbl[i].spf)),
          64'({tbl[i].res, tbl[i].flg}));

    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_out_flags", 64'(out_flags), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_l = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i]) run_op(tbl[i]);
    drain("directed");

    // back-pressure: four back-to-back offers against a stalled consumer
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(tbl[idx]);
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      drive(tbl[idx]);
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    drain("bp");

    // flush with both stages occupied; the op offered during flush is dropped
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(tbl[4]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(tbl[5]);
    @(posedge clk); #1;
    drive(tbl[6]);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_no_leak", 64'(out_valid), 64'd0);
    run_op(tbl[7]);
    drain("flush");

    // asynchronous reset in the middle of a stream
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(tbl[c]);
      @(posedge clk); #1;
    end
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    rst_l = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_result", 64'(out_result), 64'd0);
    chk("async_reset_flags", 64'(out_flags), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_l = 1'b1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    run_op(tbl[8]);
    drain("reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
